// File: rtl/dmem_responder.sv
// dmem_responder
//   Slave end of the pipeline's MEM-stage load/store port. Accepts one
//   request at a time, waits LATENCY cycles, then performs a byte/half/word
//   store or a sign/zero-extended load on an internal word array and
//   returns a single-cycle response.
//
// Ports
//   clockCPU    in   clock, rising edge
//   reset       in   synchronous, active-high
//   req_valid   in   request present
//   req_ready   out  responder idle, transfer on req_valid && req_ready
//   req_we      in   1 = store, 0 = load
//   req_funct3  in   RV32 load/store funct3
//   req_addr    in   byte address
//   req_wdata   in   right-aligned store data
//   rsp_valid   out  one-cycle response pulse
//   rsp_rdata   out  extended load data, 0 for stores and errors
//   rsp_err     out  request rejected, qualified by rsp_valid
//   busy        out  request outstanding, pipeline stall
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | ready for a request
// ST_WAIT | request latched, counting down wait states
// ST_RESP | access done on entry edge, response valid this cycle
module dmem_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000
) (
  input  logic        clockCPU,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [2:0] LAT_INIT = 3'(LATENCY);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic                  w_in_idle, w_accept, w_enter_resp, w_do_write;
  logic                  w_acc_we;
  logic [2:0]            w_acc_f3;
  logic [31:0]           w_acc_addr, w_acc_wdata;
  logic [31:0]           w_offset;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_lane;
  logic                  w_oob;
  logic [31:0]           w_word, w_shift, w_load, w_wword;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [3:0]            w_wmask;
  logic                  w_err;

  assign w_in_idle = (r_state == ST_IDLE);
  assign w_accept  = w_in_idle && req_valid;

  // With zero wait states the access happens on the accept edge, so the
  // live request fields are used instead of the latched copies.
  assign w_acc_we    = w_in_idle ? req_we     : r_we;
  assign w_acc_f3    = w_in_idle ? req_funct3 : r_f3;
  assign w_acc_addr  = w_in_idle ? req_addr   : r_addr;
  assign w_acc_wdata = w_in_idle ? req_wdata  : r_wdata;

  assign w_enter_resp = (w_accept && (LATENCY == 0)) ||
                        ((r_state == ST_WAIT) && (r_cnt == 3'd1));

  assign w_offset = w_acc_addr - BASE_ADDR;
  assign w_idx    = w_offset[ADDR_WIDTH+1:2];
  assign w_lane   = w_offset[1:0];
  assign w_oob    = |w_offset[31:ADDR_WIDTH+2];

  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_lane, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = w_lane[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_err   = w_oob;
    w_wmask = 4'b0000;
    w_wword = '0;
    w_load  = '0;
    if (w_acc_we) begin
      case (w_acc_f3)
        3'b000: begin
          w_wmask = 4'b0001 << w_lane;
          w_wword = {4{w_acc_wdata[7:0]}};
        end
        3'b001: begin
          w_wmask = w_lane[1] ? 4'b1100 : 4'b0011;
          w_wword = {2{w_acc_wdata[15:0]}};
          w_err   = w_err | w_lane[0];
        end
        3'b010: begin
          w_wmask = 4'b1111;
          w_wword = w_acc_wdata;
          w_err   = w_err | (|w_lane);
        end
        default: w_err = 1'b1;
      endcase
    end else begin
      case (w_acc_f3)
        3'b000: w_load = {{24{w_byte[7]}}, w_byte};
        3'b001: begin
          w_load = {{16{w_half[15]}}, w_half};
          w_err  = w_err | w_lane[0];
        end
        3'b010: begin
          w_load = w_word;
          w_err  = w_err | (|w_lane);
        end
        3'b100: w_load = {24'd0, w_byte};
        3'b101: begin
          w_load = {16'd0, w_half};
          w_err  = w_err | w_lane[0];
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  // Reset on the edge that would enter RESP must suppress the write.
  assign w_do_write = w_enter_resp && !reset && w_acc_we && !w_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 3'd1) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clockCPU) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_we    <= 1'b0;
      r_f3    <= 3'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= LAT_INIT;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_acc_we) ? '0 : w_load;
      end
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge clockCPU) begin
    if (w_do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wmask[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
      end
    end
  end

  assign req_ready = w_in_idle;
  assign busy      = !w_in_idle;
  assign rsp_valid = (r_state == ST_RESP) && !reset;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
